// File: rtl/fifo_circ.sv
// fifo_circ: single-clock circular-buffer FIFO with occupancy level,
// full/empty and almost-full/almost-empty flags, and a registered read path
// with a one-cycle data_valid strobe. Depth need not be a power of two.
// Optional build macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags
// (OVF/UDF) with a synchronous clear input (err_clr).
module fifo_circ #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 5,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write_event,
  input  logic              read_event,
`ifdef FIFO_ERR_FLAGS_EN
  input  logic              err_clr,
  output logic              OVF,
  output logic              UDF,
`endif
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              Q_FULL,
  output logic              Q_EMPTY,
  output logic              Q_AFULL,
  output logic              Q_AEMPTY,
  output logic [CNT_W-1:0]  level
);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  level_q, level_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              rd_acc_s, wr_acc_s;

  // Flags decode only the registered level, so no input reaches them directly.
  assign Q_FULL     = (level_q == CNT_MAX);
  assign Q_EMPTY    = (level_q == {CNT_W{1'b0}});
  assign Q_AFULL    = (level_q >= CNT_W'(AFULL_TH));
  assign Q_AEMPTY   = (level_q <= CNT_W'(AEMPTY_TH));
  assign level      = level_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;

  // Accept decisions, pointer wrap, level update and read-data selection.
  always_comb begin
    rd_acc_s     = read_event & ~Q_EMPTY;
    // A push into a full FIFO is fine when a pop frees a slot on the same edge.
    wr_acc_s     = write_event & (~Q_FULL | rd_acc_s);
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    data_out_d   = data_out_q;
    data_valid_d = rd_acc_s;

    if (wr_acc_s) begin
      // Explicit wrap so non-power-of-two depths never index past DEPTH-1.
      if (wr_ptr_q == PTR_LAST) begin
        wr_ptr_d = {PTR_W{1'b0}};
      end else begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_acc_s) begin
      data_out_d = mem_q[rd_ptr_q];
      if (rd_ptr_q == PTR_LAST) begin
        rd_ptr_d = {PTR_W{1'b0}};
      end else begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
    end else begin
      data_out_d = data_out_q;
      rd_ptr_d   = rd_ptr_q;
    end

    case ({wr_acc_s, rd_acc_s})
      2'b10:   level_d = level_q + CNT_ONE;
      2'b01:   level_d = level_q - CNT_ONE;
      default: level_d = level_q;
    endcase
  end

  // Control and read-path registers, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      level_q      <= {CNT_W{1'b0}};
      data_out_q   <= {DATA_W{1'b0}};
      data_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  assign OVF = ovf_q;
  assign UDF = udf_q;

  // Sticky error flags; a new error on the same edge wins over err_clr.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (write_event && !wr_acc_s) begin
      ovf_d = 1'b1;
    end else if (err_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (read_event && Q_EMPTY) begin
      udf_d = 1'b1;
    end else if (err_clr) begin
      udf_d = 1'b0;
    end else begin
      udf_d = udf_q;
    end
  end

  // Error flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end
`endif

endmodule
